// File: rtl/hex_dump_streamer.sv
// hex_dump_streamer: reads a block of words from a synchronous-read memory
// and streams each word as lowercase ASCII hex onto the serial transmitter's
// xmit/txchar byte interface. Words are separated by a space, and a newline
// ends each line of WORDS_PER_LINE words and also ends the final word.
//
// Byte push handshake: xmit is a one-cycle push strobe, and txchar is valid only
// while xmit=1. The transmitter has no ready signal; tx_full acts as an inverted
// ready. A push is decided in a cycle where tx_full=0 and xmit is currently
// low. The push then appears, registered, in the following cycle. This spaces
// pushes at least two cycles apart, so the FIFO full flag always reflects the
// previous push before the next push is decided.
module hex_dump_streamer #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              tx_full,
  output logic              xmit,
  output logic [7:0]        txchar,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state_o
);

  localparam int NDIG  = DATA_W / 4;
  localparam int NIB_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int LW_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  localparam logic [NIB_W-1:0] NIB_LAST  = NIB_W'(NDIG - 1);
  localparam logic [LW_W-1:0]  LINE_LAST = LW_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W:0]  REM_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_SEP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [LW_W-1:0]     line_q, line_d;
  logic [NIB_W-1:0]    nib_q, nib_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                xmit_q, xmit_d;
  logic [7:0]          txchar_q, txchar_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                can_push;

  // Map a nibble to its lowercase ASCII hex character.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

  assign can_push = !tx_full && !xmit_q;

  // Next-state and registered-output decode for the dump sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    line_d   = line_q;
    nib_d    = nib_q;
    shreg_d  = shreg_q;
    txchar_d = txchar_q;
    xmit_d   = 1'b0;
    mem_rd_d = 1'b0;
    busy_d   = busy_q;
    done_d   = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          addr_d   = base_addr;
          remain_d = count;
          line_d   = '0;
          busy_d   = 1'b1;
          if (count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_FETCH;
            mem_rd_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        shreg_d = mem_data;
        nib_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (can_push) begin
          xmit_d   = 1'b1;
          txchar_d = hex_char(shreg_q[DATA_W-1 -: 4]);
          shreg_d  = shreg_q << 4;
          if (nib_q == NIB_LAST) begin
            nib_d   = '0;
            state_d = S_SEP;
          end else begin
            nib_d = nib_q + NIB_W'(1);
          end
        end
      end
      S_SEP: begin
        if (can_push) begin
          xmit_d = 1'b1;
          if (remain_q == REM_ONE || line_q == LINE_LAST) begin
            txchar_d = 8'h0a;
            line_d   = '0;
          end else begin
            txchar_d = 8'h20;
            line_d   = line_q + LW_W'(1);
          end
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - REM_ONE;
          if (remain_q == REM_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_FETCH;
            mem_rd_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      line_q   <= '0;
      nib_q    <= '0;
      shreg_q  <= '0;
      xmit_q   <= 1'b0;
      txchar_q <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      line_q   <= line_d;
      nib_q    <= nib_d;
      shreg_q  <= shreg_d;
      xmit_q   <= xmit_d;
      txchar_q <= txchar_d;
      mem_rd_q <= mem_rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = addr_q;
  assign xmit        = xmit_q;
  assign txchar      = txchar_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hex_dump_streamer.sv
// Testbench for hex_dump_streamer: the memory model, directed dumps, and a
// scoreboard of expected transmit bytes that a negedge monitor drains.
`timescale 1ns/1ps
module tb_hex_dump_streamer;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] count = '0;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data = '0;
  logic        tx_full = 1'b0;
  logic        xmit;
  logic [7:0]  txchar;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  hex_dump_streamer #(.ADDR_W(10), .DATA_W(16), .WORDS_PER_LINE(8)) dut (
    .clk(clk), .nreset(nreset), .start(start), .base_addr(base_addr),
    .count(count), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_full(tx_full), .xmit(xmit), .txchar(txchar), .busy(busy),
    .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  // ---------------- synchronous-read memory model ----------------
  logic [15:0] mem [1024];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int push_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int tx_mode = 0;   // 0: never full, 1: random, 2: held full
  logic prev_xmit = 1'b0;
  logic prev_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!nreset) begin
      prev_xmit = 1'b0;
      prev_full = 1'b0;
    end else begin
      if (xmit) begin
        push_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_push: got 0x%0h, expected no push", txchar);
        end else begin
          check("txchar", {24'h0, txchar}, {24'h0, exp_q.pop_front()});
        end
        check("push_gap", {31'h0, prev_xmit}, 32'h0);
        check("push_while_full", {31'h0, prev_full}, 32'h0);
      end
      if (done) done_cnt++;
      if (mem_rd) rd_cnt++;
      prev_xmit = xmit;
      prev_full = tx_full;
    end
  end

  // ---------------- tx_full driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0:       tx_full = 1'b0;
        1:       tx_full = ($urandom_range(0, 2) == 0);
        default: tx_full = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic model_dump(input logic [9:0] base, input int cnt);
    string hexd = "0123456789abcdef";
    logic [15:0] w;
    logic [9:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = base + 10'(i);
      w = mem[a];
      for (int d = 3; d >= 0; d--) exp_q.push_back(hexd[int'(w[4*d +: 4])]);
      exp_q.push_back((i == cnt - 1 || (i % 8) == 7) ? 8'h0a : 8'h20);
    end
  endtask

  task automatic run_dump(input string name, input logic [9:0] base, input int cnt,
                          input bit restart, input int stall_at);
    int p0 = push_cnt;
    int d0 = done_cnt;
    int r0 = rd_cnt;
    int cyc = 0;
    int done_at = 0;
    int busy_low = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit seen = 0;
    logic busy_at_done = 1'b1;
    @(posedge clk);
    #1;
    base_addr = base;
    count = 11'(cnt);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!seen && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1;
        done_at = cyc;
        busy_at_done = busy;
      end else if (!busy) begin
        busy_low++;
      end
      if (restart && cyc == 30) begin
        base_addr = 10'h2aa;
        count = 11'd5;
        start = 1'b1;
      end else if (restart && cyc == 31) begin
        start = 1'b0;
      end
      if (stall_at > 0 && !stalled && (push_cnt - p0) >= stall_at) begin
        stalled = 1;
        tx_mode = 2;
        stall_left = 50;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tx_mode = 1;
      end
    end
    check({name, "_done_seen"}, {31'h0, seen}, 32'h1);
    check({name, "_busy_high"}, busy_low, 0);
    check({name, "_busy_at_done"}, {31'h0, busy_at_done}, 32'h0);
    if (cnt == 0) check({name, "_done_latency"}, done_at, 2);
    repeat (4) @(negedge clk);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_push_count"}, push_cnt - p0, cnt * 5);
    check({name, "_rd_count"}, rd_cnt - r0, cnt);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    int cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_xmit", {31'h0, xmit}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("rst_txchar", {24'h0, txchar}, 32'h0);
    check("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    nreset = 1'b1;

    // Basic dump with hand-written expected bytes.
    mem[0] = 16'h1234;
    mem[1] = 16'habcd;
    mem[2] = 16'h00f0;
    push_str("1234 abcd 00f0\n");
    run_dump("basic", 10'h000, 3, 0, 0);

    // Line breaking and address wrap, contents equal to address.
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    push_str("03f8 03f9 03fa 03fb 03fc 03fd 03fe 03ff\n0000 0001\n");
    run_dump("line", 10'h3f8, 10, 0, 0);

    // Zero-length dump.
    run_dump("zero", 10'h055, 0, 0, 0);

    // Start pulsed while busy must not disturb a long dump.
    for (int i = 0; i < 1024; i++) mem[i] = 16'((i * 40503) ^ (i << 3) ^ 16'h5a5a);
    model_dump(10'h010, 40);
    run_dump("restart", 10'h010, 40, 1, 0);

    // Backpressure: random tx_full with a 50-cycle hold in the middle of word 2.
    tx_mode = 1;
    model_dump(10'h040, 6);
    run_dump("stall", 10'h040, 6, 0, 6);
    tx_mode = 0;

    // Reset during the emission of word 2.
    model_dump(10'h100, 4);
    p0 = push_cnt;
    @(posedge clk);
    #1;
    base_addr = 10'h100;
    count = 11'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while ((push_cnt - p0) < 7 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached", {31'h0, (push_cnt - p0) >= 7}, 32'h1);
    nreset = 1'b0;
    @(negedge clk);
    check("rst_mid_xmit", {31'h0, xmit}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_done", {31'h0, done}, 32'h0);
    exp_q.delete();
    nreset = 1'b1;
    p0 = push_cnt;
    repeat (10) @(negedge clk);
    check("rst_mid_quiet", push_cnt - p0, 0);
    model_dump(10'h200, 3);
    run_dump("after_reset", 10'h200, 3, 0, 0);

    // Full-memory dump.
    model_dump(10'h000, 1024);
    run_dump("full", 10'h000, 1024, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_dump_streamer.md
Name: hex_dump_streamer

Overview:
- Downstream feeder for the serial transmit path. On a start strobe from the command controller, reads a block of words from a synchronous-read memory (e.g. a spectrogram BRAM).
- Emits each word as lowercase ASCII hex, one character per transmit push, on the same xmit/txchar byte interface the serial transmitter accepts.
- Paced by the transmitter FIFO full flag, so arbitrarily long dumps never overrun it.

Parameters:
- ADDR_W, 10, memory address width in words.
- DATA_W, 16, memory word width; must be a multiple of 4. NDIG = DATA_W/4 hex digits per word.
- WORDS_PER_LINE, 8, words per output line before a newline replaces the space separator.

Ports:
- clk  in  1  system clock.
- nreset  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle strobe; latches base_addr and count when idle.
- base_addr  in  ADDR_W  first word address.
- count  in  ADDR_W+1  number of words to dump, 0..2^ADDR_W.
- mem_rd  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory read address.
- mem_data  in  DATA_W  read data, valid exactly one cycle after mem_rd.
- tx_full  in  1  transmitter FIFO full flag.
- xmit  out  1  one-cycle byte push strobe.
- txchar  out  8  byte to push, valid while xmit=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion strobe.

Behaviour:
- **Reset** (nreset=0 at clk edge): state IDLE. mem_rd, xmit, busy and done are 0; txchar, mem_addr, word counter and nibble index are 0. Reset mid-dump abandons it immediately; no further xmit.
- All outputs are registered.
- **IDLE:** start=1 latches base_addr into the address register, count into the remaining counter, and clears the line-word counter.
  - If count=0: go to DONE; no characters are sent.
  - Otherwise go to FETCH.
  - start while busy=1 is ignored.
- **FETCH:** assert mem_rd=1 and mem_addr=current address for one cycle, then go to WAIT.
- **WAIT:** capture mem_data into a shift register at the end of this cycle, then go to EMIT with nibble index 0.
- **EMIT:**
  - Characters are sent MS nibble first.
  - Nibble n maps to 0x30+n for n≤9 and 0x61+(n−10) for n≥10, so output is always lowercase.
  - A character is issued (xmit=1, txchar set, for one cycle) only when tx_full=0 in the issuing cycle and no xmit was issued in the previous cycle. This gives at most one push per 2 cycles, so the FIFO flag has settled before the next push.
  - After the NDIG-th digit go to SEP.
- **SEP:** issue one separator character under the same pacing rule.
  - Separator is 0x0A if this is the last word, or if the line-word counter equals WORDS_PER_LINE−1 (the counter then clears).
  - Otherwise separator is 0x20 and the line-word counter increments.
  - Then: address increments modulo 2^ADDR_W (wrap allowed); remaining count decrements.
  - If remaining=0 go to DONE, else go to FETCH.
- **DONE:** done=1 for exactly one cycle, then go to IDLE; busy drops in the same cycle done rises.
- **Pacing:** while tx_full=1, state, txchar and counters hold and xmit=0; the dump resumes with no lost or duplicated characters.
- **Output size:** a dump of N>0 words produces exactly N·(NDIG+1) pushes.

Test Plan:
1. **Basic dump.** Memory [0]=0x1234, [1]=0xabcd, [2]=0x00f0; start with base=0, count=3, tx_full=0. Required pushes: "1234 abcd 00f0\n" (15 bytes, 0x0A last). Pushes are ≥2 cycles apart, followed by a single done pulse.
2. **Line breaking.** base=0x3F8, count=10, contents = address value. Required: 8 words with a newline after the 8th, then 2 words with a newline. Address wraps 0x3FF→0x000 (words "03ff 0000").
3. **Zero count.** count=0: no xmit and no mem_rd; done pulses 2 cycles after start. A start pulsed again while busy during a long dump has no effect on output.
4. **Backpressure.** Hold tx_full=1 for 50 cycles mid-word, toggling randomly elsewhere. Byte stream must be identical to the unstalled case, and no xmit may occur while tx_full=1.
5. **Reset mid-operation.** Drop nreset during EMIT of word 2. Next cycle: xmit=0, busy=0, done=0. A fresh start then dumps correctly from the new base.
6. **Full-memory dump.** count=1024: 5120 pushes, done once, busy high throughout.
